// File: rtl/mem_pkg.sv
// Shared definitions for the external-bus memory responder: write-FSM encoding
// and default address map.
package mem_pkg;

  localparam int          DEFAULT_ADDR_BITS = 10;
  localparam logic [15:0] DEFAULT_IO_ADDR   = 16'hFF00;

  localparam logic [1:0] W_IDLE   = 2'd0;
  localparam logic [1:0] W_ACTIVE = 2'd1;
  localparam logic [1:0] W_COMMIT = 2'd2;

  // True when the address falls in the low RAM window (all bits above the index are zero).
  function automatic logic in_ram_window(input logic [15:0] addr, input int abits);
    return (addr >> abits) == 16'd0;
  endfunction

endpackage

// File: rtl/tristate.sv
// Generic tri-state driver: places din on the shared bus while en is high,
// otherwise releases it.
module tristate #(
  parameter int WIDTH = 8
) (
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  inout  wire  [WIDTH-1:0] bus
);

  assign bus = en ? din : {WIDTH{1'bz}};

endmodule

// File: rtl/mem_responder.sv
// CPU external-bus responder: 2^ADDR_BITS-byte RAM, one memory-mapped I/O register,
// combinational reads with commit bypass, strobe-driven write FSM.
module mem_responder
  import mem_pkg::*;
#(
  parameter int          ADDR_BITS = DEFAULT_ADDR_BITS,
  parameter logic [15:0] IO_ADDR   = DEFAULT_IO_ADDR
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] address,
  inout  wire  [7:0]  data,
  input  logic        rd,
  input  logic        wr,
  input  logic [7:0]  port_in,
  output logic [7:0]  port_out,
  output logic        bus_err,
  output logic [15:0] wr_count
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [7:0]           ram [DEPTH];

  logic [1:0]           state_reg;
  logic [1:0]           state_next;
  logic [15:0]          lat_addr_reg;
  logic [7:0]           lat_data_reg;
  logic                 latch_en;
  logic                 do_commit;

  logic                 hit_io;
  logic                 hit_ram;
  logic                 lat_hit_io;
  logic                 lat_hit_ram;
  logic [ADDR_BITS-1:0] idx;
  logic [ADDR_BITS-1:0] lat_idx;

  logic                 bypass;
  logic                 read_en;
  logic [7:0]           rd_data;

  assign hit_io      = (address == IO_ADDR);
  assign hit_ram     = in_ram_window(address, ADDR_BITS);
  assign idx         = address[ADDR_BITS-1:0];

  assign lat_hit_io  = (lat_addr_reg == IO_ADDR);
  assign lat_hit_ram = in_ram_window(lat_addr_reg, ADDR_BITS);
  assign lat_idx     = lat_addr_reg[ADDR_BITS-1:0];

  // Write FSM: latch on every low-sampled strobe edge so the final sample wins;
  // commit one edge after the strobe is seen high.
  always_comb begin
    state_next = state_reg;
    latch_en   = 1'b0;
    do_commit  = 1'b0;
    case (state_reg)
      W_IDLE: begin
        if (!wr) begin
          latch_en   = 1'b1;
          state_next = W_ACTIVE;
        end
      end
      W_ACTIVE: begin
        if (!wr) begin
          latch_en = 1'b1;
        end else begin
          state_next = W_COMMIT;
        end
      end
      W_COMMIT: begin
        do_commit = 1'b1;
        if (!wr) begin
          latch_en   = 1'b1;
          state_next = W_ACTIVE;
        end else begin
          state_next = W_IDLE;
        end
      end
      default: state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= W_IDLE;
      port_out  <= 8'h00;
      bus_err   <= 1'b0;
      wr_count  <= 16'h0000;
    end else begin
      state_reg <= state_next;
      if (latch_en) begin
        lat_addr_reg <= address;
        lat_data_reg <= data;
      end
      if (do_commit) begin
        wr_count <= wr_count + 16'd1;
        if (lat_hit_io) begin
          port_out <= lat_data_reg;
        end
      end
      if (!rd && !wr) begin
        bus_err <= 1'b1;
      end
    end
  end

  // RAM contents survive reset; reset only suppresses an in-flight commit.
  always_ff @(posedge clock) begin
    if (!reset && do_commit && lat_hit_ram) begin
      ram[lat_idx] <= lat_data_reg;
    end
  end

  assign bypass  = (state_reg == W_COMMIT) && lat_hit_ram && (lat_idx == idx);
  assign read_en = !rd && wr && (hit_ram || hit_io);

  always_comb begin
    rd_data = ram[idx];
    if (hit_io) begin
      rd_data = port_in;
    end else if (bypass) begin
      rd_data = lat_data_reg;
    end
  end

  tristate #(
    .WIDTH(8)
  ) u_data_tri (
    .en  (read_en),
    .din (rd_data),
    .bus (data)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: directed scenarios plus randomized bus traffic
// checked against a simple transaction-level memory model.
module tb_mem_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] address = 16'h0000;
  logic        rd = 1'b1;
  logic        wr = 1'b1;
  logic [7:0]  port_in = 8'h00;
  logic [7:0]  port_out;
  logic        bus_err;
  logic [15:0] wr_count;
  logic        tb_oe = 1'b0;
  logic [7:0]  tb_dout = 8'h00;
  wire  [7:0]  data;

  assign data = tb_oe ? tb_dout : 8'bz;

  always #5 clock = ~clock;

  mem_responder dut (
    .clock    (clock),
    .reset    (reset),
    .address  (address),
    .data     (data),
    .rd       (rd),
    .wr       (wr),
    .port_in  (port_in),
    .port_out (port_out),
    .bus_err  (bus_err),
    .wr_count (wr_count)
  );

  typedef struct {
    string       name;
    bit          chk_data;
    bit          exp_float;
    logic [7:0]  exp_data;
    bit          chk_stat;
    logic [7:0]  exp_port;
    logic [15:0] exp_cnt;
    bit          exp_err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;
  bit   sample = 1'b0;

  // Transaction-level reference model
  logic [7:0]  m_mem [int];
  logic [7:0]  m_port = 8'h00;
  logic [15:0] m_cnt = 16'h0000;
  bit          m_err = 1'b0;
  bit          commit_pending = 1'b0;
  logic [15:0] written[$];

  function automatic void chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endfunction

  function automatic void model_write(input logic [15:0] a, input logic [7:0] d);
    m_cnt = m_cnt + 16'd1;
    if (a < 16'd1024) begin
      m_mem[int'(a)] = d;
      written.push_back(a);
    end else if (a == 16'hFF00) begin
      m_port = d;
    end
  endfunction

  // Monitor: compares whenever the stimulus flags a sampled observation.
  always @(negedge clock) begin
    if (sample) begin
      if (sb.size() == 0) begin
        chk("scoreboard_underflow", 16'd1, 16'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.chk_data) begin
          if (e.exp_float) chk({e.name, "_float"}, {15'd0, dut.read_en}, 16'd0);
          else             chk({e.name, "_data"}, {8'd0, data}, {8'd0, e.exp_data});
        end
        if (e.chk_stat) begin
          chk({e.name, "_port_out"}, {8'd0, port_out}, {8'd0, e.exp_port});
          chk({e.name, "_wr_count"}, wr_count, e.exp_cnt);
          chk({e.name, "_bus_err"}, {15'd0, bus_err}, {15'd0, e.exp_err});
        end
      end
      $display("txn %s addr=%h data=%h port_out=%h wr_count=%0d bus_err=%0b",
               (sb.size() >= 0) ? "obs" : "", address, data, port_out, wr_count, bus_err);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    commit_pending = 1'b0;
  endtask

  task automatic idle(input int n);
    rd = 1'b1; wr = 1'b1; tb_oe = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rd = 1'b1; wr = 1'b1; tb_oe = 1'b0; reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    m_port = 8'h00; m_cnt = 16'h0000; m_err = 1'b0; commit_pending = 1'b0;
  endtask

  // Strobe held low n edges; earlier edges carry junk so only the last sample may land.
  task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      rd = 1'b1; wr = 1'b0; tb_oe = 1'b1;
      if (i == n - 1) begin
        address = a; tb_dout = d;
      end else begin
        address = 16'($urandom); tb_dout = 8'($urandom);
      end
      tick();
    end
    wr = 1'b1; tb_oe = 1'b0;
    tick();
    model_write(a, d);
    commit_pending = 1'b1;
  endtask

  task automatic do_read(input logic [15:0] a, input string nm);
    exp_t e;
    rd = 1'b0; wr = 1'b1; tb_oe = 1'b0; address = a;
    e.name = nm; e.chk_data = 1'b1; e.exp_float = 1'b0; e.exp_data = 8'h00;
    if (a == 16'hFF00)      e.exp_data = port_in;
    else if (a < 16'd1024)  e.exp_data = m_mem[int'(a)];
    else                    e.exp_float = 1'b1;
    e.chk_stat = !commit_pending;
    e.exp_port = m_port; e.exp_cnt = m_cnt; e.exp_err = m_err;
    sb.push_back(e);
    sample = 1'b1;
    tick();
    sample = 1'b0;
    rd = 1'b1;
  endtask

  task automatic do_status(input string nm);
    exp_t e;
    if (commit_pending) idle(1);
    rd = 1'b1; wr = 1'b1; tb_oe = 1'b0;
    e.name = nm; e.chk_data = 1'b1; e.exp_float = 1'b1; e.exp_data = 8'h00;
    e.chk_stat = 1'b1; e.exp_port = m_port; e.exp_cnt = m_cnt; e.exp_err = m_err;
    sb.push_back(e);
    sample = 1'b1;
    tick();
    sample = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    do_status("reset_state");

    // RAM write then read
    do_write(16'h0010, 8'hA5, 2);
    idle(1);
    do_read(16'h0010, "ram_rw");

    // Output and input ports
    do_write(16'hFF00, 8'h3C, 1);
    do_status("port_out");
    port_in = 8'h81;
    do_read(16'hFF00, "port_in");

    // Unmapped write must not alias onto RAM[0]
    do_write(16'h0000, 8'h5B, 1);
    do_write(16'h0800, 8'h77, 1);
    do_read(16'h0800, "unmapped");
    idle(1);
    do_read(16'h0000, "ram0_kept");

    // Bypass during commit, with an older value still in RAM
    do_write(16'h0040, 8'h10, 1);
    idle(1);
    do_write(16'h0040, 8'h99, 2);
    do_read(16'h0040, "bypass_old");
    do_write(16'h0001, 8'h11, 1);
    do_read(16'h0001, "bypass");

    // Back-to-back writes
    do_write(16'h0003, 8'h33, 1);
    do_write(16'h0002, 8'h22, 1);
    idle(1);
    do_read(16'h0003, "b2b_first");
    do_read(16'h0002, "b2b_second");
    do_status("b2b_count");

    // Collision: driver stays off, write still commits, flag is sticky
    rd = 1'b0; wr = 1'b0; tb_oe = 1'b1; address = 16'h0030; tb_dout = 8'h5A;
    begin
      exp_t e;
      e.name = "collision"; e.chk_data = 1'b1; e.exp_float = 1'b1; e.exp_data = 8'h00;
      e.chk_stat = 1'b0; e.exp_port = 8'h00; e.exp_cnt = 16'h0000; e.exp_err = 1'b0;
      sb.push_back(e);
    end
    sample = 1'b1;
    tick();
    sample = 1'b0;
    rd = 1'b1; wr = 1'b1; tb_oe = 1'b0;
    tick();
    m_err = 1'b1;
    model_write(16'h0030, 8'h5A);
    commit_pending = 1'b1;
    do_status("collision_flag");
    do_read(16'h0030, "collision_wr");
    idle(3);
    do_status("collision_sticky");

    // Reset mid-write aborts the commit
    do_write(16'h0020, 8'h5D, 1);
    idle(1);
    rd = 1'b1; wr = 1'b0; tb_oe = 1'b1; address = 16'h0020; tb_dout = 8'hEE;
    tick(); tick();
    reset = 1'b1;
    tick();
    wr = 1'b1; tb_oe = 1'b0;
    tick();
    reset = 1'b0;
    m_port = 8'h00; m_cnt = 16'h0000; m_err = 1'b0; commit_pending = 1'b0;
    idle(2);
    do_status("rst_mid");
    do_read(16'h0020, "rst_mid_ram");

    // Randomized traffic
    for (int t = 0; t < 200; t++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 3) begin
        do_write(16'($urandom_range(0, 63)), 8'($urandom), $urandom_range(1, 3));
      end else if (op == 4) begin
        do_write(16'hFF00, 8'($urandom), $urandom_range(1, 3));
      end else if (op == 5) begin
        do_write({6'($urandom_range(1, 62)), 10'($urandom)}, 8'($urandom), $urandom_range(1, 2));
      end else if (op <= 7 && written.size() > 0) begin
        do_read(written[$urandom_range(0, written.size() - 1)], "rand_ram");
      end else if (op == 8) begin
        port_in = 8'($urandom);
        do_read(16'hFF00, "rand_io");
      end else begin
        do_read({6'($urandom_range(1, 62)), 10'($urandom)}, "rand_unmapped");
        do_status("rand_status");
      end
    end

    idle(3);
    chk("scoreboard_drain", 16'(sb.size()), 16'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Bus responder on the far end of the 8-bit CPU's external bus. It serves reads from and commits writes into an internal 1 KByte RAM. It also exposes one memory-mapped output port and one input port. It replaces the behavioural testbench memory as the synthesizable memory subsystem, sitting directly on `address`/`data`/`rd`/`wr`.

## Interface
- `ADDR_BITS`, 10: RAM index width; RAM depth is 2^ADDR_BITS bytes.
- `IO_ADDR`, 16'hFF00: full 16-bit address of the I/O register (write = output port, read = input port).
- `clock`  in  1  single system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset, sampled on the rising edge of `clock`.
- `address`  in  16  CPU address bus.
- `data`  inout  8  bidirectional CPU data bus; driven only during a decoded read.
- `rd`  in  1  active-low read strobe.
- `wr`  in  1  active-low write strobe.
- `port_in`  in  8  external input port, returned on reads of `IO_ADDR`.
- `port_out`  out  8  output port register, loaded by writes to `IO_ADDR`.
- `bus_err`  out  1  sticky flag: `rd` and `wr` were both sampled low on the same edge.
- `wr_count`  out  16  number of committed writes, wrapping.

## Operation
- **Address decode**
  - `hit_io` = (`address` == `IO_ADDR`).
  - `hit_ram` = (`address[15:ADDR_BITS]` == 0), i.e. the low RAM window only.
  - Any other address is unmapped: reads float the bus and writes are dropped (still counted, see below).
- **Read path** (combinational)
  - `data` is driven when `rd`=0, `wr`=1 and (`hit_ram` or `hit_io`).
  - The driven value is `ram[address[ADDR_BITS-1:0]]` or `port_in`.
  - Otherwise `data` is high-Z.
  - Read bypass: if a commit is pending for the same RAM index in the current cycle, the pending byte is returned.
- **Write FSM** (registered, states `W_IDLE`, `W_ACTIVE`, `W_COMMIT`)
  - `W_IDLE`: `wr` sampled 0 → latch `address` and `data` → `W_ACTIVE`.
  - `W_ACTIVE`: while `wr`=0, re-latch `address`/`data` every edge, so the last sample before the strobe rises wins. When `wr` is sampled 1 → `W_COMMIT`.
  - `W_COMMIT`: write the latched byte to RAM (if `hit_ram`) or to `port_out` (if `hit_io`), and increment `wr_count`. Next state is `W_ACTIVE` if `wr`=0 (back-to-back write), else `W_IDLE`.
  - A write to an unmapped address still passes through `W_COMMIT` and increments `wr_count`, but modifies nothing.
- **Collision**
  - `rd`=0 and `wr`=0 on the same edge sets `bus_err`. It stays set until reset.
  - During a collision the read driver stays off; the write proceeds normally.
- **Reset**
  - Outputs: `port_out`=8'h00, `bus_err`=0, `wr_count`=0, FSM=`W_IDLE`, `data` high-Z.
  - RAM contents are not cleared.
  - Reset asserted during `W_ACTIVE` or `W_COMMIT` aborts the write: no RAM or port update, no count.
- **Counter**: `wr_count` is 16-bit and wraps 16'hFFFF → 16'h0000.

## Timing
- Read latency: combinational; valid data follows `address`/`rd` within the same cycle.
- Write strobe: `wr` must be held low for at least one rising edge. Shorter pulses are not captured.
- Write commit: RAM/`port_out` update on the first rising edge after `wr` is sampled high, i.e. 1 cycle after the strobe's trailing sample.
  - A read of that location in the same cycle as `W_COMMIT` returns the new byte via bypass.
  - A read on any later cycle returns it from RAM.
- `wr_count` and `port_out` update on the same edge as the RAM write.
- Minimum write-to-write spacing: `wr` high for one sampled edge between strobes.

## Structure
- Shared package `mem_pkg`: write-FSM state encoding (2-bit), default `IO_ADDR`, default `ADDR_BITS`.
- The sub-module is the codebase's existing `tristate` (8-bit) driving `data`. There is one instance, enabled by the read-decode term.
- RAM is an internal register array with asynchronous read and synchronous write.

## Test plan
- **RAM write then read.** Reset; write 8'hA5 to 16'h0010 with `wr` low for 2 cycles; then read 16'h0010 → `data`=8'hA5, `wr_count`=1.
- **Output and input ports.** Write 8'h3C to 16'hFF00 → `port_out`=8'h3C one cycle after `wr` rises. Set `port_in`=8'h81 and read 16'hFF00 → `data`=8'h81.
- **Unmapped address.** Write 8'h77 to 16'h0800, then read 16'h0800 → `data` high-Z; `wr_count` increments; RAM[0] unchanged.
- **Back-to-back writes and bypass.** Write 8'h11 to 16'h0001 and immediately 8'h22 to 16'h0002, reading 16'h0001 during the first `W_COMMIT` → read returns 8'h11; both bytes stored; `wr_count`=2.
- **Collision.** Hold `rd`=0 and `wr`=0 for one cycle → `bus_err`=1 and `data` not driven; write commits. `bus_err` is cleared only by `reset`.
- **Reset mid-write.** Assert `reset` while in `W_ACTIVE` with data 8'hEE at 16'h0020 → RAM[0x20] unchanged, `wr_count`=0, FSM=`W_IDLE`.
